// File: rtl/decode_issue_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module   : decode_issue_stage_pkg
// Desc     : Shared types and default latencies for the decode/issue stage:
//            RV32 opcode/funct3 encodings, issue unit selector and the
//            decoded-instruction record carried in the issue slot.
// Revision : 1.0 - initial release
// ============================================================================
package decode_issue_stage_pkg;

    localparam int C_NUM_REGS     = 32;
    localparam int C_REG_W        = 5;
    localparam int C_DATA_W       = 32;
    localparam int C_LOAD_LATENCY = 1;
    localparam int C_MUL_LATENCY  = 4;

    typedef logic [31:0] instruction_t;

    typedef enum logic [6:0] {
        OPC_LUI      = 7'b0110111,
        OPC_AUIPC    = 7'b0010111,
        OPC_JAL      = 7'b1101111,
        OPC_JALR     = 7'b1100111,
        OPC_BRANCH   = 7'b1100011,
        OPC_LOAD     = 7'b0000011,
        OPC_STORE    = 7'b0100011,
        OPC_OP_IMM   = 7'b0010011,
        OPC_OP       = 7'b0110011,
        OPC_MISC_MEM = 7'b0001111,
        OPC_SYSTEM   = 7'b1110011
    } opcode_t;

    typedef enum logic [2:0] {
        F3_PRIV   = 3'b000,
        F3_CSRRW  = 3'b001,
        F3_CSRRS  = 3'b010,
        F3_CSRRC  = 3'b011,
        F3_CSRRWI = 3'b101,
        F3_CSRRSI = 3'b110,
        F3_CSRRCI = 3'b111
    } system_funct3_t;

    typedef enum logic [1:0] {
        ALU = 2'd0,
        MEM = 2'd1,
        MUL = 2'd2
    } issue_unit_t;

    typedef struct packed {
        logic [C_REG_W-1:0]  rs1;
        logic [C_REG_W-1:0]  rs2;
        logic [C_REG_W-1:0]  rd;
        logic                rs1_needed;
        logic                rs2_needed;
        logic                is_wb;
        issue_unit_t         unit;
        logic [C_DATA_W-1:0] imm;
        logic [4:0]          shamt;
        logic [C_DATA_W-1:0] pc;
    } decoded_instr_t;

endpackage
`default_nettype wire

// File: rtl/decode_issue_stage_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : issue_scoreboard
// Desc     : Per-register remaining-latency counters. Answers RAW/WAW hazard
//            queries for the instruction being decoded, taking the entry
//            still sitting in the issue slot into account.
// Revision : 1.0 - initial release
// ============================================================================
module issue_scoreboard #(
    parameter int NUM_REGS       = 32,
    parameter int REGISTER_WIDTH = 5,
    parameter int CNT_WIDTH      = 3
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      set_en_i,
    input  logic [REGISTER_WIDTH-1:0] set_idx_i,
    input  logic [CNT_WIDTH-1:0]      set_val_i,
    input  logic                      held_block_en_i,
    input  logic [REGISTER_WIDTH-1:0] held_rd_i,
    input  logic [REGISTER_WIDTH-1:0] rs1_i,
    input  logic                      rs1_needed_i,
    input  logic [REGISTER_WIDTH-1:0] rs2_i,
    input  logic                      rs2_needed_i,
    input  logic [REGISTER_WIDTH-1:0] rd_i,
    input  logic                      is_wb_i,
    output logic                      raw_o,
    output logic                      waw_o,
    output logic [NUM_REGS-1:0]       pending_o
);

    logic [CNT_WIDTH-1:0] r_cnt [NUM_REGS];
    logic [NUM_REGS-1:0]  w_pending;
    logic                 w_blk_rs1;
    logic                 w_blk_rs2;
    logic                 w_blk_rd;

    // Counters: load on issue of a multi-cycle producer, otherwise count down; x0 stays 0
    always_ff @(posedge clk_i) begin
        for (int r = 0; r < NUM_REGS; r++) begin
            if (rst_i || r == 0) begin
                r_cnt[r] <= '0;
            end else if (set_en_i && set_idx_i == REGISTER_WIDTH'(r)) begin
                r_cnt[r] <= set_val_i;
            end else if (r_cnt[r] != '0) begin
                r_cnt[r] <= r_cnt[r] - CNT_WIDTH'(1);
            end
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_pending
        assign w_pending[g] = (r_cnt[g] != '0);
    end

    assign pending_o = w_pending;

    // Hazard queries against both the counters and the not-yet-retired slot entry
    always_comb begin
        w_blk_rs1 = held_block_en_i && (held_rd_i == rs1_i);
        w_blk_rs2 = held_block_en_i && (held_rd_i == rs2_i);
        w_blk_rd  = held_block_en_i && (held_rd_i == rd_i);
        raw_o = (rs1_needed_i && (rs1_i != '0) && (w_pending[rs1_i] || w_blk_rs1))
             || (rs2_needed_i && (rs2_i != '0) && (w_pending[rs2_i] || w_blk_rs2));
        waw_o = is_wb_i && (rd_i != '0) && (w_pending[rd_i] || w_blk_rd);
    end

endmodule
`default_nettype wire

// File: rtl/decode_issue_stage.sv
`default_nettype none
// ============================================================================
// Module   : decode_issue_stage
// Desc     : RV32 decode plus a single registered issue slot with valid/ready
//            handshakes, latency-scoreboard hazard stalls and flush support.
// Config   : DECODE_STATS_EN adds saturating RAW/WAW stall-cycle counters.
// Revision : 1.0 - initial release
// ============================================================================
module decode_issue_stage
    import decode_issue_stage_pkg::*;
#(
    parameter int NUM_REGS       = C_NUM_REGS,
    parameter int REGISTER_WIDTH = C_REG_W,
    parameter int DATA_WIDTH     = C_DATA_W,
    parameter int LOAD_LATENCY   = C_LOAD_LATENCY,
    parameter int MUL_LATENCY    = C_MUL_LATENCY,
    parameter int CNT_WIDTH      = $clog2(MUL_LATENCY + 1)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    input  instruction_t          instruction_i,
    input  logic [DATA_WIDTH-1:0] pc_i,
    input  logic                  flush_i,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output decoded_instr_t        out_decoded_o,
    output logic [NUM_REGS-1:0]   sb_pending_o
`ifdef DECODE_STATS_EN
    ,
    output logic [31:0]           raw_stall_cnt_o,
    output logic [31:0]           waw_stall_cnt_o
`endif
);

    opcode_t              w_opcode;
    logic [2:0]           w_funct3;
    decoded_instr_t       w_dec;
    logic [CNT_WIDTH-1:0] w_lat;

    decoded_instr_t       r_slot;
    logic                 r_valid;
    logic [CNT_WIDTH-1:0] r_lat;

    logic w_fire;
    logic w_accept;
    logic w_raw;
    logic w_waw;
    logic w_hazard;
    logic w_held_block_en;
    logic w_sb_set_en;

    // RV32 field extraction, operand usage, immediate and result latency
    always_comb begin
        w_opcode   = opcode_t'(instruction_i[6:0]);
        w_funct3   = instruction_i[14:12];
        w_dec      = '0;
        w_dec.rs1  = instruction_i[19:15];
        w_dec.rs2  = instruction_i[24:20];
        w_dec.rd   = instruction_i[11:7];
        w_dec.pc   = pc_i;
        w_dec.unit = ALU;
        w_lat      = '0;
        case (w_opcode)
            OPC_LUI, OPC_AUIPC: begin
                w_dec.is_wb = 1'b1;
                w_dec.imm   = {instruction_i[31:12], 12'b0};
            end
            OPC_JAL: begin
                w_dec.is_wb = 1'b1;
                w_dec.imm   = {{11{instruction_i[31]}}, instruction_i[31], instruction_i[19:12],
                               instruction_i[20], instruction_i[30:21], 1'b0};
            end
            OPC_JALR: begin
                w_dec.rs1_needed = 1'b1;
                w_dec.is_wb      = 1'b1;
                w_dec.imm        = {{20{instruction_i[31]}}, instruction_i[31:20]};
            end
            OPC_BRANCH: begin
                w_dec.rs1_needed = 1'b1;
                w_dec.rs2_needed = 1'b1;
                w_dec.imm        = {{19{instruction_i[31]}}, instruction_i[31], instruction_i[7],
                                    instruction_i[30:25], instruction_i[11:8], 1'b0};
            end
            OPC_LOAD: begin
                w_dec.rs1_needed = 1'b1;
                w_dec.is_wb      = 1'b1;
                w_dec.unit       = MEM;
                w_dec.imm        = {{20{instruction_i[31]}}, instruction_i[31:20]};
                w_lat            = CNT_WIDTH'(LOAD_LATENCY);
            end
            OPC_STORE: begin
                w_dec.rs1_needed = 1'b1;
                w_dec.rs2_needed = 1'b1;
                w_dec.unit       = MEM;
                w_dec.imm        = {{20{instruction_i[31]}}, instruction_i[31:25], instruction_i[11:7]};
            end
            OPC_OP_IMM: begin
                w_dec.rs1_needed = 1'b1;
                w_dec.is_wb      = 1'b1;
                w_dec.imm        = {{20{instruction_i[31]}}, instruction_i[31:20]};
                if (w_funct3[1:0] == 2'b01) begin
                    w_dec.shamt = instruction_i[24:20];
                end
            end
            OPC_OP: begin
                w_dec.rs1_needed = 1'b1;
                w_dec.rs2_needed = 1'b1;
                w_dec.is_wb      = 1'b1;
                if (instruction_i[31:25] == 7'b0000001) begin
                    w_dec.unit = MUL;
                    w_lat      = CNT_WIDTH'(MUL_LATENCY);
                end
            end
            OPC_SYSTEM: begin
                w_dec.imm = {{20{instruction_i[31]}}, instruction_i[31:20]};
                case (system_funct3_t'(w_funct3))
                    F3_CSRRW, F3_CSRRS, F3_CSRRC: begin
                        w_dec.rs1_needed = 1'b1;
                        w_dec.is_wb      = 1'b1;
                    end
                    F3_CSRRWI, F3_CSRRSI, F3_CSRRCI: begin
                        w_dec.is_wb = 1'b1;
                    end
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

    // Handshake: a slot entry that retires with zero latency no longer blocks readers
    always_comb begin
        w_fire          = r_valid && out_ready_i;
        w_held_block_en = r_valid && r_slot.is_wb && !(w_fire && (r_lat == '0));
        w_sb_set_en     = w_fire && r_slot.is_wb && (r_slot.rd != '0) && (r_lat != '0);
        w_hazard        = w_raw || w_waw;
        w_accept        = in_valid_i && !flush_i && !w_hazard && (!r_valid || out_ready_i);
        in_ready_o      = flush_i || (!w_hazard && (!r_valid || out_ready_i));
    end

    issue_scoreboard #(
        .NUM_REGS       (NUM_REGS),
        .REGISTER_WIDTH (REGISTER_WIDTH),
        .CNT_WIDTH      (CNT_WIDTH)
    ) u_scoreboard (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .set_en_i        (w_sb_set_en),
        .set_idx_i       (r_slot.rd),
        .set_val_i       (r_lat - CNT_WIDTH'(1)),
        .held_block_en_i (w_held_block_en),
        .held_rd_i       (r_slot.rd),
        .rs1_i           (w_dec.rs1),
        .rs1_needed_i    (w_dec.rs1_needed),
        .rs2_i           (w_dec.rs2),
        .rs2_needed_i    (w_dec.rs2_needed),
        .rd_i            (w_dec.rd),
        .is_wb_i         (w_dec.is_wb),
        .raw_o           (w_raw),
        .waw_o           (w_waw),
        .pending_o       (sb_pending_o)
    );

    // Issue slot: flush discards, accept loads, bare fire empties, otherwise hold
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_valid <= 1'b0;
            r_slot  <= '0;
            r_lat   <= '0;
        end else if (flush_i) begin
            r_valid <= 1'b0;
        end else if (w_accept) begin
            r_valid <= 1'b1;
            r_slot  <= w_dec;
            r_lat   <= w_lat;
        end else if (w_fire) begin
            r_valid <= 1'b0;
        end
    end

    assign out_valid_o   = r_valid;
    assign out_decoded_o = r_slot;

`ifdef DECODE_STATS_EN
    logic [31:0] r_raw_stall_cnt;
    logic [31:0] r_waw_stall_cnt;

    // Saturating stall-cycle counters; a RAW stall is never also counted as WAW
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_raw_stall_cnt <= '0;
            r_waw_stall_cnt <= '0;
        end else if (in_valid_i && !flush_i) begin
            if (w_raw) begin
                if (r_raw_stall_cnt != '1) r_raw_stall_cnt <= r_raw_stall_cnt + 32'd1;
            end else if (w_waw) begin
                if (r_waw_stall_cnt != '1) r_waw_stall_cnt <= r_waw_stall_cnt + 32'd1;
            end
        end
    end

    assign raw_stall_cnt_o = r_raw_stall_cnt;
    assign waw_stall_cnt_o = r_waw_stall_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_decode_issue_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_decode_issue_stage
// Desc     : Directed self-checking bench for decode_issue_stage: reset,
//            decode fields, ALU/load/MUL dependency timing, WAW stall,
//            flush with and without fire, and reset mid-operation.
// Revision : 1.0 - initial release
// ============================================================================
module tb_decode_issue_stage;
    import decode_issue_stage_pkg::*;

    localparam logic [6:0] c_op_r    = 7'b0110011;
    localparam logic [6:0] c_op_imm  = 7'b0010011;
    localparam logic [6:0] c_op_load = 7'b0000011;

    logic           clk = 1'b0;
    logic           rst;
    logic           in_valid;
    logic           in_ready;
    instruction_t   instruction;
    logic [31:0]    pc;
    logic           flush;
    logic           out_valid;
    logic           out_ready;
    decoded_instr_t out_decoded;
    logic [31:0]    sb_pending;
`ifdef DECODE_STATS_EN
    logic [31:0]    raw_cnt;
    logic [31:0]    waw_cnt;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    decode_issue_stage dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .in_valid_i    (in_valid),
        .in_ready_o    (in_ready),
        .instruction_i (instruction),
        .pc_i          (pc),
        .flush_i       (flush),
        .out_valid_o   (out_valid),
        .out_ready_i   (out_ready),
        .out_decoded_o (out_decoded),
        .sb_pending_o  (sb_pending)
`ifdef DECODE_STATS_EN
        ,
        .raw_stall_cnt_o (raw_cnt),
        .waw_stall_cnt_o (waw_cnt)
`endif
    );

    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3,
                                          input logic [4:0] rd, input logic [6:0] op);
        return {f7, rs2, rs1, f3, rd, op};
    endfunction

    function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd,
                                          input logic [6:0] op);
        return {imm, rs1, f3, rd, op};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        in_valid  = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < n; k++) step();
    endtask

    // Offer a then b with out_ready=1; measure b's stall cycles, fire spacing
    // and how many cycles sb_pending[idx] is high.
    task automatic run_pair(input logic [31:0] a, input logic [31:0] b, input int idx,
                            output int stall_b, output int gap, output int pend);
        int fire_a;
        int fire_b;
        bit a_done;
        bit b_done;
        fire_a = -1; fire_b = -1; a_done = 0; b_done = 0;
        stall_b = 0; pend = 0;
        in_valid = 1'b1; instruction = a; out_ready = 1'b1; flush = 1'b0;
        for (int cyc = 0; cyc < 40 && fire_b < 0; cyc++) begin
            @(negedge clk);
            if (sb_pending[idx]) pend++;
            if (out_valid && out_ready) begin
                if (fire_a < 0) fire_a = cyc;
                else            fire_b = cyc;
            end
            if (in_valid && !b_done) begin
                if (in_ready) begin
                    if (!a_done) a_done = 1;
                    else         b_done = 1;
                end else if (a_done) begin
                    stall_b++;
                end
            end
            step();
            if (a_done && !b_done) instruction = b;
            if (b_done) in_valid = 1'b0;
        end
        in_valid = 1'b0;
        gap = (fire_a >= 0 && fire_b >= 0) ? (fire_b - fire_a) : -1;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
        instruction = '0; pc = '0;
        step(); step();
        rst = 1'b0;
        @(negedge clk);
        n_tests++;
        if (out_valid !== 1'b0 || out_decoded !== '0 || sb_pending !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_state: valid=%b dec=%h pend=%h, need 0/0/0",
                     out_valid, out_decoded, sb_pending);
        end
        n_tests++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_in_ready: got %b need 1", in_ready);
        end
    endtask

    task automatic test_decode();
        logic [31:0] vec  [7];
        logic [4:0]  flg  [7];   // {rs1_needed, rs2_needed, is_wb, unit}
        logic [31:0] imm  [7];
        vec[0] = {7'd0, 5'd2, 5'd1, 3'b010, 5'd8, 7'b0100011};  flg[0] = {3'b110, MEM}; imm[0] = 32'd8;          // sw x2,8(x1)
        vec[1] = {20'h12345, 5'd4, 7'b0110111};                 flg[1] = {3'b001, ALU}; imm[1] = 32'h12345000;   // lui x4
        vec[2] = enc_i(12'hFFF, 5'd1, 3'b000, 5'd3, c_op_imm);  flg[2] = {3'b101, ALU}; imm[2] = 32'hFFFFFFFF;   // addi x3,x1,-1
        vec[3] = enc_i(12'd3, 5'd2, 3'b001, 5'd1, c_op_imm);    flg[3] = {3'b101, ALU}; imm[3] = 32'd3;          // slli x1,x2,3
        vec[4] = enc_i(12'h300, 5'd6, 3'b001, 5'd5, 7'b1110011);flg[4] = {3'b101, ALU}; imm[4] = 32'h300;        // csrrw x5,x6
        vec[5] = 32'h30200073;                                  flg[5] = {3'b000, ALU}; imm[5] = 32'h302;        // mret
        vec[6] = enc_r(7'd1, 5'd2, 5'd1, 3'b000, 5'd9, c_op_r); flg[6] = {3'b111, MUL}; imm[6] = 32'd0;          // mul x9
        for (int k = 0; k < 7; k++) begin
            in_valid = 1'b1; instruction = vec[k]; pc = 32'h100 + 32'(4 * k); out_ready = 1'b1;
            step();
            in_valid = 1'b0;
            @(negedge clk);
            n_tests++;
            if (out_valid !== 1'b1 ||
                {out_decoded.rs1_needed, out_decoded.rs2_needed, out_decoded.is_wb, out_decoded.unit} !== flg[k] ||
                out_decoded.imm !== imm[k] || out_decoded.pc !== 32'h100 + 32'(4 * k)) begin
                n_fail++;
                $display("FAIL decode_%0d: valid=%b flags=%b imm=%h pc=%h, need 1 %b %h %h", k, out_valid,
                         {out_decoded.rs1_needed, out_decoded.rs2_needed, out_decoded.is_wb, out_decoded.unit},
                         out_decoded.imm, out_decoded.pc, flg[k], imm[k], 32'h100 + 32'(4 * k));
            end
            if (k == 3) begin
                n_tests++;
                if (out_decoded.shamt !== 5'd3 || out_decoded.rd !== 5'd1) begin
                    n_fail++;
                    $display("FAIL decode_shamt: shamt=%0d rd=%0d need 3 1", out_decoded.shamt, out_decoded.rd);
                end
            end
            step();
        end
        idle(6);
    endtask

    task automatic test_back_to_back();
        int st, gap, pend;
        run_pair(enc_r(7'd0, 5'd2, 5'd1, 3'b000, 5'd5, c_op_r),
                 enc_r(7'd0, 5'd5, 5'd5, 3'b000, 5'd6, c_op_r), 5, st, gap, pend);
        n_tests++;
        if (st !== 0 || gap !== 1 || pend !== 0) begin
            n_fail++;
            $display("FAIL alu_alu: stalls=%0d gap=%0d pend=%0d need 0 1 0", st, gap, pend);
        end
        idle(4);
    endtask

    task automatic test_load_use();
        int st, gap, pend;
        run_pair(enc_i(12'd0, 5'd1, 3'b010, 5'd7, c_op_load),
                 enc_r(7'd0, 5'd0, 5'd7, 3'b000, 5'd8, c_op_r), 7, st, gap, pend);
        n_tests++;
        if (st !== 1 || gap !== 2) begin
            n_fail++;
            $display("FAIL load_use: stalls=%0d gap=%0d need 1 2", st, gap);
        end
        idle(4);
    endtask

    task automatic test_mul_use();
        int st, gap, pend;
`ifdef DECODE_STATS_EN
        logic [31:0] raw0;
        raw0 = raw_cnt;
`endif
        run_pair(enc_r(7'd1, 5'd2, 5'd1, 3'b000, 5'd9, c_op_r),
                 enc_r(7'd0, 5'd1, 5'd9, 3'b000, 5'd10, c_op_r), 9, st, gap, pend);
        n_tests++;
        if (st !== 4 || gap !== 5 || pend !== 3) begin
            n_fail++;
            $display("FAIL mul_use: stalls=%0d gap=%0d pend=%0d need 4 5 3", st, gap, pend);
        end
`ifdef DECODE_STATS_EN
        n_tests++;
        if (raw_cnt - raw0 !== 32'd4) begin
            n_fail++;
            $display("FAIL mul_use_raw_stats: delta=%0d need 4", raw_cnt - raw0);
        end
`endif
        idle(6);
    endtask

    task automatic test_waw();
        int st, gap, pend;
`ifdef DECODE_STATS_EN
        logic [31:0] raw0, waw0;
        raw0 = raw_cnt; waw0 = waw_cnt;
`endif
        run_pair(enc_r(7'd1, 5'd2, 5'd1, 3'b000, 5'd9, c_op_r),
                 enc_i(12'd1, 5'd0, 3'b000, 5'd9, c_op_imm), 9, st, gap, pend);
        n_tests++;
        if (st !== 4 || gap !== 5 || pend !== 3) begin
            n_fail++;
            $display("FAIL waw: stalls=%0d gap=%0d pend=%0d need 4 5 3", st, gap, pend);
        end
`ifdef DECODE_STATS_EN
        n_tests++;
        if (waw_cnt - waw0 !== 32'd4 || raw_cnt - raw0 !== 32'd0) begin
            n_fail++;
            $display("FAIL waw_stats: waw=%0d raw=%0d need 4 0", waw_cnt - waw0, raw_cnt - raw0);
        end
`endif
        idle(6);
    endtask

    task automatic test_flush();
        // hold mul x3 in a stalled slot, then flush
        in_valid = 1'b1; instruction = enc_r(7'd1, 5'd2, 5'd1, 3'b000, 5'd3, c_op_r);
        out_ready = 1'b0; flush = 1'b0;
        step();
        instruction = enc_r(7'd0, 5'd2, 5'd1, 3'b000, 5'd11, c_op_r);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            n_tests++;
            if (out_valid !== 1'b1 || out_decoded.rd !== 5'd3 || out_decoded.unit !== MUL ||
                in_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL stall_hold_%0d: valid=%b rd=%0d unit=%0d in_ready=%b need 1 3 2 0",
                         k, out_valid, out_decoded.rd, out_decoded.unit, in_ready);
            end
            step();
        end
        flush = 1'b1; instruction = enc_r(7'd0, 5'd0, 5'd3, 3'b000, 5'd12, c_op_r);
        @(negedge clk);
        n_tests++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL flush_in_ready: got %b need 1", in_ready);
        end
        step();
        flush = 1'b0; in_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            n_tests++;
            if (out_valid !== 1'b0 || sb_pending[3] !== 1'b0) begin
                n_fail++;
                $display("FAIL flush_discard_%0d: valid=%b pend3=%b need 0 0", k, out_valid, sb_pending[3]);
            end
            step();
        end
        // flush coinciding with fire still records the retiring mul
        in_valid = 1'b1; instruction = enc_r(7'd1, 5'd2, 5'd1, 3'b000, 5'd3, c_op_r); out_ready = 1'b0;
        step();
        in_valid = 1'b0; out_ready = 1'b1; flush = 1'b1;
        step();
        flush = 1'b0;
        @(negedge clk);
        n_tests++;
        if (out_valid !== 1'b0 || sb_pending[3] !== 1'b1) begin
            n_fail++;
            $display("FAIL flush_fire: valid=%b pend3=%b need 0 1", out_valid, sb_pending[3]);
        end
        idle(6);
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b1;
        in_valid = 1'b1; instruction = enc_r(7'd1, 5'd2, 5'd1, 3'b000, 5'd9, c_op_r);
        step();                                   // mul x9 accepted
        instruction = enc_r(7'd0, 5'd2, 5'd1, 3'b000, 5'd13, c_op_r);
        step();                                   // mul fires, add x13 accepted
        in_valid = 1'b0; out_ready = 1'b0;
        step();                                   // cnt[9] 3 -> 2
        @(negedge clk);
        n_tests++;
        if (sb_pending[9] !== 1'b1 || out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL pre_reset: pend9=%b valid=%b need 1 1", sb_pending[9], out_valid);
        end
        rst = 1'b1;
        step();
        rst = 1'b0; out_ready = 1'b1;
        in_valid = 1'b1; instruction = enc_r(7'd0, 5'd1, 5'd9, 3'b000, 5'd10, c_op_r);
        @(negedge clk);
        n_tests++;
        if (sb_pending !== 32'd0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_mid: pend=%h valid=%b in_ready=%b need 0 0 1", sb_pending, out_valid, in_ready);
        end
`ifdef DECODE_STATS_EN
        n_tests++;
        if (raw_cnt !== 32'd0 || waw_cnt !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_stats: raw=%0d waw=%0d need 0 0", raw_cnt, waw_cnt);
        end
`endif
        step();
        in_valid = 1'b0;
        @(negedge clk);
        n_tests++;
        if (out_valid !== 1'b1 || out_decoded.rd !== 5'd10) begin
            n_fail++;
            $display("FAIL reset_dep_issue: valid=%b rd=%0d need 1 10", out_valid, out_decoded.rd);
        end
        idle(3);
    endtask

    initial begin
        test_reset();
        test_decode();
        test_back_to_back();
        test_load_use();
        test_mul_use();
        test_waw();
        test_flush();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
